decoder_rr_arbiter: RTL

DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

---
 rtl/dec_arb_pkg.sv | 32 +++
 rtl/decoder_rr_arbiter_dec2to4.sv | 16 +
 rtl/decoder_rr_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/dec_arb_pkg.sv
// Shared definitions for the decoder-based round-robin arbiter:
// FSM encoding, MAX_HOLD bounds and the rotating-priority search.
package dec_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } state_e;

   localparam int MAX_HOLD_MIN = 1;
   localparam int MAX_HOLD_MAX = 16;
   localparam int MAX_HOLD_DEF = 8;

   // First requester found when scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
      logic [1:0] pick;
      logic [1:0] idx;
      logic       found;
      pick  = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/decoder_rr_arbiter_dec2to4.sv
// 2-to-4 one-hot decoder with enable; sel_a is the select MSB.
module dec2to4 (
   input  logic       sel_a,
   input  logic       sel_b,
   input  logic       dec_en,
   output logic [3:0] gnt
);

   always_comb begin
      gnt = 4'b0000;
      if (dec_en) begin
         gnt[{sel_a, sel_b}] = 1'b1;
      end
   end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Four-requester round-robin arbiter: IDLE/GRANT/GAP FSM with a hold limit,
// whose registered owner and enable drive a 2-to-4 decoder to form the grant.
module decoder_rr_arbiter
   import dec_arb_pkg::*;
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic       sel_a,
   output logic       sel_b,
   output logic       dec_en,
   output logic [1:0] owner,
   output logic       busy
);

   localparam int                HOLD_W    = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   if (MAX_HOLD < MAX_HOLD_MIN || MAX_HOLD > MAX_HOLD_MAX) begin : g_bad_max_hold
      $error("decoder_rr_arbiter: MAX_HOLD must be within 1..16");
   end

   state_e            state_q, state_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        owner_q, owner_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              dec_en_q, dec_en_d;
   logic              busy_q, busy_d;

   // IDLE and GAP arbitrate identically; GAP differs only in having just rotated ptr.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      owner_d  = owner_q;
      hold_d   = hold_q;
      dec_en_d = 1'b0;
      busy_d   = 1'b1;
      case (state_q)
         ST_IDLE, ST_GAP: begin
            if (req != 4'b0000) begin
               owner_d  = rr_pick(req, ptr_q);
               hold_d   = '0;
               state_d  = ST_GRANT;
               dec_en_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         ST_GRANT: begin
            if (!req[owner_q] || hold_q == HOLD_LAST) begin
               state_d = ST_GAP;
               ptr_d   = owner_q + 2'd1;
            end else begin
               hold_d   = hold_q + HOLD_W'(1);
               dec_en_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 2'd0;
         owner_q  <= 2'd0;
         hold_q   <= '0;
         dec_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         owner_q  <= owner_d;
         hold_q   <= hold_d;
         dec_en_q <= dec_en_d;
         busy_q   <= busy_d;
      end
   end

   assign owner  = owner_q;
   assign sel_a  = owner_q[1];
   assign sel_b  = owner_q[0];
   assign dec_en = dec_en_q;
   assign busy   = busy_q;

   dec2to4 u_dec (
      .sel_a  (sel_a),
      .sel_b  (sel_b),
      .dec_en (dec_en),
      .gnt    (gnt)
   );

endmodule
